// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the RV32I multi-cycle control unit.
// Covers opcodes, control encodings, fault codes and FSM state codes.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_SRX  = 3'b101;

    localparam logic [1:0] IMM_I   = 2'b00;
    localparam logic [1:0] IMM_S   = 2'b01;
    localparam logic [3:0] ALU_ADD = 4'b0000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        CLS_OP,
        CLS_OP_IMM,
        CLS_LOAD,
        CLS_STORE
    } instr_cls_e;

    // Field order matches the {ImmSel, BSel, ALUSel, WBSel} output concatenation.
    typedef struct packed {
        logic [1:0] imm_sel;
        logic       b_sel;
        logic [3:0] alu_sel;
        logic       wb_sel;
    } ctrl_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Instruction-memory fetch bus: the request is held until the acknowledge arrives,
// and rdata is valid in the cycle where both req and ack are high.
interface rv_multicycle_ctrl_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/rv_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct fields -> class, legality and the
// datapath control bundle that the FSM latches in DECODE.
module rv_ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output instr_cls_e cls,
    output logic       legal,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        cls   = CLS_OP;
        legal = 1'b0;
        ctrl  = '0;
        case (opcode)
            OPC_OP: begin
                cls          = CLS_OP;
                legal        = 1'b1;
                ctrl.imm_sel = IMM_I;
                ctrl.b_sel   = 1'b0;
                ctrl.alu_sel = {funct7_5, funct3};
                ctrl.wb_sel  = 1'b1;
            end
            OPC_OP_IMM: begin
                // Immediate bit 30 only selects arithmetic shift for SRAI.
                cls          = CLS_OP_IMM;
                legal        = 1'b1;
                ctrl.imm_sel = IMM_I;
                ctrl.b_sel   = 1'b1;
                ctrl.alu_sel = {funct7_5 && (funct3 == F3_SRX), funct3};
                ctrl.wb_sel  = 1'b1;
            end
            OPC_LOAD: begin
                cls          = CLS_LOAD;
                legal        = (funct3 == F3_WORD);
                ctrl.imm_sel = IMM_I;
                ctrl.b_sel   = 1'b1;
                ctrl.alu_sel = ALU_ADD;
                ctrl.wb_sel  = 1'b0;
            end
            OPC_STORE: begin
                cls          = CLS_STORE;
                legal        = (funct3 == F3_WORD);
                ctrl.imm_sel = IMM_S;
                ctrl.b_sel   = 1'b1;
                ctrl.alu_sel = ALU_ADD;
                ctrl.wb_sel  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch over req/ack, decode, then sequence EXEC/MEM/WB so
// that each instruction issues at most one register or memory write.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        run,
    rv_multicycle_ctrl_if.master        imem,
    output logic [31:0]                 instructionCode,
    output logic [1:0]                  ImmSel,
    output logic                        RegWEn,
    output logic                        BSel,
    output logic [3:0]                  ALUSel,
    output logic                        MemRW,
    output logic                        WBSel,
    output logic [31:0]                 pc,
    output logic                        retire,
    output logic [1:0]                  fault
);

    localparam logic [3:0] WAIT_LAST = 4'(FETCH_TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  state_d;
    logic [3:0]  wait_cnt;
    logic [31:0] ir;
    fault_e      fault_q;

    instr_cls_e  cls;
    logic        legal;
    ctrl_t       dec_ctrl;
    logic        is_mem;
    logic        timeout;

    rv_ctrl_decode u_decode (
        .opcode   (ir[6:0]),
        .funct3   (ir[14:12]),
        .funct7_5 (ir[30]),
        .cls      (cls),
        .legal    (legal),
        .ctrl     (dec_ctrl)
    );

    assign is_mem          = (cls == CLS_LOAD) || (cls == CLS_STORE);
    assign timeout         = (wait_cnt == WAIT_LAST);
    assign instructionCode = ir;
    assign fault           = fault_q;
    assign imem.req        = (state == ST_FETCH);
    assign imem.addr       = pc;

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   state_d = run ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                if (imem.ack)    state_d = ST_DECODE;
                else if (timeout) state_d = ST_TRAP;
            end
            ST_DECODE: state_d = legal ? ST_EXEC : ST_TRAP;
            ST_EXEC:   state_d = is_mem ? ST_MEM : ST_WB;
            ST_MEM:    state_d = ST_WB;
            ST_WB:     state_d = run ? ST_FETCH : ST_IDLE;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: reset is sampled here synchronously and written first so it beats every update below.
        if (RST) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            ir       <= NOP_INSTR;
            wait_cnt <= '0;
            ImmSel   <= IMM_I;
            BSel     <= 1'b0;
            ALUSel   <= '0;
            WBSel    <= 1'b0;
            RegWEn   <= 1'b0;
            MemRW    <= 1'b0;
            retire   <= 1'b0;
            fault_q  <= FAULT_NONE;
        end else begin
            state    <= state_d;
            wait_cnt <= (state == ST_FETCH && !imem.ack) ? wait_cnt + 4'd1 : '0;

            if (state == ST_FETCH && imem.ack)
                ir <= imem.rdata;
            if (state == ST_FETCH && !imem.ack && timeout)
                fault_q <= FAULT_TIMEOUT;

            if (state == ST_DECODE) begin
                if (legal) {ImmSel, BSel, ALUSel, WBSel} <= dec_ctrl;
                else       fault_q <= FAULT_ILLEGAL;
            end

            if (state == ST_WB)
                pc <= pc + 32'd4;

            // Strobes are keyed on the next state so they line up exactly with MEM/WB.
            RegWEn <= (state_d == ST_WB) && (cls != CLS_STORE);
            MemRW  <= (state_d == ST_MEM) && (cls == CLS_STORE);
            retire <= (state_d == ST_WB);
        end
    end

endmodule
